mips_cpu_branch_unit: RTL and testbench
=======================================

# mips_cpu_branch_unit

Registered branch/jump resolution unit for the multicycle MIPS core. It decodes all MIPS-I control-transfer instructions and evaluates their conditions on the register operands. It computes the target and link address, then holds the redirect until a configurable number of delay-slot fetches have completed. It sits between decode/register-read and the PC register, and presents a valid/ready redirect to fetch.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width (≥ ADDR_WIDTH)
- ADDR_WIDTH, 32, PC width (≥ 28)
- DELAY_SLOTS, 1, delay-slot fetches before redirect (0..3)
- STAT_WIDTH, 16, statistics counter width

Ports:
- clk  in  1  single clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- instr_valid  in  1  decoded fields and operands valid this cycle
- opcode  in  6  instr[31:26]
- fn  in  6  instr[5:0]
- rt_field  in  5  instr[20:16]
- rd_field  in  5  instr[15:11]
- imm16  in  16  instr[15:0]
- instr_index  in  26  instr[25:0]
- rs_data  in  DATA_WIDTH  rs operand
- rt_data  in  DATA_WIDTH  rt operand
- pc_plus4  in  ADDR_WIDTH  address of the delay slot
- slot_fetched  in  1  one delay-slot instruction fetched, one pulse per slot
- redirect_ready  in  1  fetch accepts the redirect
- busy  out  1  unit not IDLE; upstream must stall control transfers
- redirect_valid  out  1  redirect pending
- redirect_addr  out  ADDR_WIDTH  target address
- link_valid  out  1  one-cycle write request for the link register
- link_reg  out  5  31 for JAL/BxxZAL, rd_field for JALR
- link_addr  out  ADDR_WIDTH  pc_plus4 + 4
- addr_fault  out  1  one-cycle pulse: JR/JALR target misaligned
- taken_count, not_taken_count  out  STAT_WIDTH  only with BRANCH_STATS_EN

## Operation
- Decode:
  - J = 02, JAL = 03.
  - JR = 00/fn 08, JALR = 00/fn 09.
  - BEQ = 04, BNE = 05, BLEZ = 06, BGTZ = 07.
  - REGIMM = 01 with rt_field: BLTZ = 00, BGEZ = 01, BLTZAL = 10h, BGEZAL = 11h.
  - Any other opcode is not a control transfer and causes no action.
- Conditions use signed DATA_WIDTH compares: eq (rs == rt), neg (rs < 0), zero (rs == 0). BLEZ = neg|zero; BGTZ = !neg&!zero; BGEZ = !neg.
- Targets:
  - Branches: pc_plus4 + (sign-extended imm16 << 2), modulo 2^ADDR_WIDTH.
  - J/JAL: {pc_plus4[ADDR_WIDTH-1:28], instr_index, 2'b00}.
  - JR/JALR: rs_data[ADDR_WIDTH-1:0].
- Link: JAL, JALR, BLTZAL and BGEZAL assert link_valid whether taken or not.
- FSM states IDLE, SLOT, REDIRECT:
  - IDLE, instr_valid with a taken transfer → latch target; go to SLOT, or to REDIRECT if DELAY_SLOTS = 0.
  - IDLE, not-taken transfer or non-transfer → stay in IDLE.
  - SLOT: count slot_fetched pulses. Move to REDIRECT on the cycle the count reaches DELAY_SLOTS.
  - REDIRECT: redirect_valid = 1 and redirect_addr stays stable until redirect_valid & redirect_ready. Then go to IDLE.
- Boundary conditions:
  - instr_valid while busy: ignored entirely; no link, no fault, no stats.
  - slot_fetched in IDLE or REDIRECT: ignored.
  - JR/JALR with target[1:0] ≠ 0: addr_fault pulses and the link is still written. No redirect occurs and the unit stays in IDLE.
  - Reset mid-operation: returns to IDLE and drops any pending redirect. It also clears the slot counter and stats.

## Timing
- Reset values:
  - busy, redirect_valid, link_valid, addr_fault = 0.
  - redirect_addr, link_addr, link_reg = 0.
  - Counters = 0; state = IDLE.
- Decision registered at the instr_valid edge; all outputs are registered.
- link_valid, link_reg, link_addr and addr_fault appear exactly 1 cycle after instr_valid, for 1 cycle.
- busy rises 1 cycle after an accepted taken transfer and falls the cycle after the redirect handshake.
- DELAY_SLOTS = 0: redirect_valid rises 1 cycle after instr_valid.
- DELAY_SLOTS = N: redirect_valid rises the cycle after the Nth slot_fetched.
- A slot_fetched arriving in the same cycle as SLOT entry is not counted.
- Minimum gap between two taken transfers is 2 cycles (DELAY_SLOTS = 0, ready held at 1).

## Configuration
- BRANCH_STATS_EN defined:
  - taken_count increments once per accepted taken transfer (including jumps and faults); not_taken_count increments once per accepted not-taken conditional branch.
  - Both counters saturate at all-ones and update 1 cycle after instr_valid.
- Undefined: the stats ports and counters are absent; all other behaviour is identical.

## Test plan
- BEQ, rs = rt = 5, pc_plus4 = 0x100, imm16 = 0xFFFF, DELAY_SLOTS = 1 → no redirect before slot_fetched. After slot_fetched, redirect_valid with redirect_addr = 0xFC, held 3 cycles with ready = 0, then cleared the cycle after ready.
- BGEZAL, rs = 0xFFFFFFFF, pc_plus4 = 0x400 → not taken. link_valid 1 cycle with link_reg = 31 and link_addr = 0x404; no redirect; busy stays 0.
- JALR, rd_field = 9, rs = 0x1002 → addr_fault pulse and link write to reg 9 (0x…+4 of pc_plus4). No redirect.
- J with instr_index = 0x0000040, pc_plus4 = 0xB0000010 → redirect_addr = 0xB0000100. A second instr_valid (BNE, taken) during SLOT is ignored, as is a slot_fetched in IDLE.
- Reset asserted in REDIRECT with ready = 0 → next cycle redirect_valid = 0 and busy = 0. A following BEQ is handled normally.
- BRANCH_STATS_EN, STAT_WIDTH = 2: five taken BNE → taken_count = 3 (saturated); three not-taken BLEZ → not_taken_count = 3.

Source files
------------

// File: rtl/mips_cpu_branch_unit_if.sv
// Redirect handshake between the branch unit and fetch.
// master: redirect_valid/redirect_addr out, redirect_ready in; slave: reverse.
interface mips_cpu_branch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  redirect_valid;
    logic                  redirect_ready;
    logic [ADDR_WIDTH-1:0] redirect_addr;

    modport master (
        output redirect_valid,
        output redirect_addr,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_addr,
        output redirect_ready
    );
endinterface

// File: rtl/mips_cpu_branch_unit.sv
// Registered MIPS-I branch/jump resolution with delay-slot hold-off.
// Ports: i_clk/i_reset, decoded fields + operands in, i_slot_fetched,
// o_busy, o_link_*, o_addr_fault, redirect via if_redir (master).
// Optional BRANCH_STATS_EN adds o_taken_count/o_not_taken_count.
module mips_cpu_branch_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DELAY_SLOTS = 1,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_instr_valid,
    input  logic [5:0]            i_opcode,
    input  logic [5:0]            i_fn,
    input  logic [4:0]            i_rt_field,
    input  logic [4:0]            i_rd_field,
    input  logic [15:0]           i_imm16,
    input  logic [25:0]           i_instr_index,
    input  logic [DATA_WIDTH-1:0] i_rs_data,
    input  logic [DATA_WIDTH-1:0] i_rt_data,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic                  i_slot_fetched,
    mips_cpu_branch_unit_if.master if_redir,
    output logic                  o_busy,
    output logic                  o_link_valid,
    output logic [4:0]            o_link_reg,
    output logic [ADDR_WIDTH-1:0] o_link_addr,
`ifdef BRANCH_STATS_EN
    output logic [STAT_WIDTH-1:0] o_taken_count,
    output logic [STAT_WIDTH-1:0] o_not_taken_count,
`endif
    output logic                  o_addr_fault
);

    typedef enum logic [1:0] {
        IDLE,
        SLOT,
        REDIRECT
    } state_t;

    state_t                r_state;
    logic [1:0]            r_slot_cnt;
    logic [ADDR_WIDTH-1:0] r_target;
    logic                  r_redirect_valid;
    logic                  r_busy;
    logic                  r_link_valid;
    logic [4:0]            r_link_reg;
    logic [ADDR_WIDTH-1:0] r_link_addr;
    logic                  r_addr_fault;

    // Decode
    logic w_j, w_jal, w_jr, w_jalr;
    logic w_beq, w_bne, w_blez, w_bgtz;
    logic w_bltz, w_bgez, w_bltzal, w_bgezal;
    logic w_regimm, w_special;

    assign w_special = (i_opcode == 6'h00);
    assign w_regimm  = (i_opcode == 6'h01);
    assign w_j       = (i_opcode == 6'h02);
    assign w_jal     = (i_opcode == 6'h03);
    assign w_beq     = (i_opcode == 6'h04);
    assign w_bne     = (i_opcode == 6'h05);
    assign w_blez    = (i_opcode == 6'h06);
    assign w_bgtz    = (i_opcode == 6'h07);
    assign w_jr      = w_special && (i_fn == 6'h08);
    assign w_jalr    = w_special && (i_fn == 6'h09);
    assign w_bltz    = w_regimm && (i_rt_field == 5'h00);
    assign w_bgez    = w_regimm && (i_rt_field == 5'h01);
    assign w_bltzal  = w_regimm && (i_rt_field == 5'h10);
    assign w_bgezal  = w_regimm && (i_rt_field == 5'h11);

    logic w_branch, w_jump_abs, w_jump_reg, w_xfer, w_link;

    assign w_branch   = w_beq | w_bne | w_blez | w_bgtz |
                        w_bltz | w_bgez | w_bltzal | w_bgezal;
    assign w_jump_abs = w_j | w_jal;
    assign w_jump_reg = w_jr | w_jalr;
    assign w_xfer     = w_branch | w_jump_abs | w_jump_reg;
    assign w_link     = w_jal | w_jalr | w_bltzal | w_bgezal;

    // Conditions (signed: negative is just the sign bit)
    logic w_eq, w_neg, w_zero, w_cond;

    assign w_eq   = (i_rs_data == i_rt_data);
    assign w_neg  = i_rs_data[DATA_WIDTH-1];
    assign w_zero = (i_rs_data == '0);

    always_comb begin
        w_cond = 1'b0;
        unique case (1'b1)
            w_beq:              w_cond = w_eq;
            w_bne:              w_cond = !w_eq;
            w_blez:             w_cond = w_neg | w_zero;
            w_bgtz:             w_cond = !w_neg & !w_zero;
            w_bltz | w_bltzal:  w_cond = w_neg;
            w_bgez | w_bgezal:  w_cond = !w_neg;
            default:            w_cond = 1'b0;
        endcase
    end

    logic w_taken;
    assign w_taken = w_jump_abs | w_jump_reg | (w_branch & w_cond);

    // Targets
    logic [ADDR_WIDTH-1:0] w_br_off, w_br_tgt, w_j_tgt, w_jr_tgt;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_fault;

    assign w_br_off = {{(ADDR_WIDTH-18){i_imm16[15]}}, i_imm16, 2'b00};
    assign w_br_tgt = i_pc_plus4 + w_br_off;
    assign w_j_tgt  = {i_pc_plus4[ADDR_WIDTH-1:28], i_instr_index, 2'b00};
    assign w_jr_tgt = i_rs_data[ADDR_WIDTH-1:0];
    assign w_fault  = w_jump_reg && (w_jr_tgt[1:0] != 2'b00);

    always_comb begin
        w_target = w_br_tgt;
        if (w_jump_abs)
            w_target = w_j_tgt;
        else if (w_jump_reg)
            w_target = w_jr_tgt;
    end

    logic w_accept;
    assign w_accept = i_instr_valid && (r_state == IDLE) && w_xfer;

    // Slot counting: the count that would result from this pulse
    logic [2:0] w_cnt_inc;
    assign w_cnt_inc = {1'b0, r_slot_cnt} + 3'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_slot_cnt       <= '0;
            r_target         <= '0;
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
            r_link_valid     <= 1'b0;
            r_link_reg       <= '0;
            r_link_addr      <= '0;
            r_addr_fault     <= 1'b0;
        end else begin
            r_link_valid <= 1'b0;
            r_addr_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_slot_cnt <= '0;
                    if (w_accept) begin
                        if (w_link) begin
                            r_link_valid <= 1'b1;
                            r_link_reg   <= w_jalr ? i_rd_field : 5'd31;
                            r_link_addr  <= i_pc_plus4 + ADDR_WIDTH'(4);
                        end
                        if (w_fault) begin
                            r_addr_fault <= 1'b1;
                        end else if (w_taken) begin
                            r_target <= w_target;
                            r_busy   <= 1'b1;
                            if (DELAY_SLOTS == 0) begin
                                r_state          <= REDIRECT;
                                r_redirect_valid <= 1'b1;
                            end else begin
                                r_state <= SLOT;
                            end
                        end
                    end
                end
                SLOT: begin
                    if (i_slot_fetched) begin
                        r_slot_cnt <= w_cnt_inc[1:0];
                        if (w_cnt_inc == 3'(DELAY_SLOTS)) begin
                            r_state          <= REDIRECT;
                            r_redirect_valid <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (if_redir.redirect_ready) begin
                        r_state          <= IDLE;
                        r_redirect_valid <= 1'b0;
                        r_busy           <= 1'b0;
                        r_slot_cnt       <= '0;
                    end
                end
                default: begin
                    r_state          <= IDLE;
                    r_redirect_valid <= 1'b0;
                    r_busy           <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_WIDTH-1:0] r_taken_count;
    logic [STAT_WIDTH-1:0] r_not_taken_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_taken_count     <= '0;
            r_not_taken_count <= '0;
        end else if (w_accept) begin
            if (w_taken) begin
                if (r_taken_count != '1)
                    r_taken_count <= r_taken_count + 1'b1;
            end else begin
                if (r_not_taken_count != '1)
                    r_not_taken_count <= r_not_taken_count + 1'b1;
            end
        end
    end

    assign o_taken_count     = r_taken_count;
    assign o_not_taken_count = r_not_taken_count;
`endif

    assign if_redir.redirect_valid = r_redirect_valid;
    assign if_redir.redirect_addr  = r_target;
    assign o_busy                  = r_busy;
    assign o_link_valid            = r_link_valid;
    assign o_link_reg              = r_link_reg;
    assign o_link_addr             = r_link_addr;
    assign o_addr_fault            = r_addr_fault;

endmodule

// File: tb/tb_mips_cpu_branch_unit.sv
// Directed testbench for mips_cpu_branch_unit (DELAY_SLOTS = 1).
// Stats checks are compiled in when BRANCH_STATS_EN is defined.
module tb_mips_cpu_branch_unit;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic [5:0]    opcode;
    logic [5:0]    fn;
    logic [4:0]    rt_field;
    logic [4:0]    rd_field;
    logic [15:0]   imm16;
    logic [25:0]   instr_index;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [AW-1:0] pc_plus4;
    logic          slot_fetched;
    logic          busy;
    logic          link_valid;
    logic [4:0]    link_reg;
    logic [AW-1:0] link_addr;
    logic          addr_fault;
`ifdef BRANCH_STATS_EN
    logic [SW-1:0] taken_count;
    logic [SW-1:0] not_taken_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mips_cpu_branch_unit_if #(.ADDR_WIDTH(AW)) rif ();

    mips_cpu_branch_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DELAY_SLOTS(1),
        .STAT_WIDTH (SW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_instr_valid(instr_valid),
        .i_opcode     (opcode),
        .i_fn         (fn),
        .i_rt_field   (rt_field),
        .i_rd_field   (rd_field),
        .i_imm16      (imm16),
        .i_instr_index(instr_index),
        .i_rs_data    (rs_data),
        .i_rt_data    (rt_data),
        .i_pc_plus4   (pc_plus4),
        .i_slot_fetched(slot_fetched),
        .if_redir     (rif.master),
        .o_busy       (busy),
        .o_link_valid (link_valid),
        .o_link_reg   (link_reg),
        .o_link_addr  (link_addr),
`ifdef BRANCH_STATS_EN
        .o_taken_count    (taken_count),
        .o_not_taken_count(not_taken_count),
`endif
        .o_addr_fault (addr_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] f,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input logic [25:0] idx,
                         input logic [31:0] rs, input logic [31:0] rtv,
                         input logic [31:0] pc4);
        opcode      = op;
        fn          = f;
        rt_field    = rt;
        rd_field    = rd;
        imm16       = imm;
        instr_index = idx;
        rs_data     = rs;
        rt_data     = rtv;
        pc_plus4    = pc4;
        instr_valid = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        instr_valid  = 1'b0;
        opcode       = '0;
        fn           = '0;
        rt_field     = '0;
        rd_field     = '0;
        imm16        = '0;
        instr_index  = '0;
        rs_data      = '0;
        rt_data      = '0;
        pc_plus4     = '0;
        slot_fetched = 1'b0;
        rif.redirect_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rv", 32'(rif.redirect_valid), 32'd0);
        check("rst_raddr", rif.redirect_addr, 32'h0);
        check("rst_lv", 32'(link_valid), 32'd0);
        check("rst_lreg", 32'(link_reg), 32'd0);
        check("rst_laddr", link_addr, 32'h0);
        check("rst_fault", 32'(addr_fault), 32'd0);
`ifdef BRANCH_STATS_EN
        check("rst_tc", 32'(taken_count), 32'd0);
        check("rst_ntc", 32'(not_taken_count), 32'd0);
`endif

        // BEQ taken, backward by one word: 0x100 - 4 = 0xFC
        instr(6'h04, 6'h0, 5'h0, 5'h0, 16'hFFFF, 26'h0, 32'd5, 32'd5, 32'h100);
        step();
        instr_valid = 1'b0;
        check("beq_busy", 32'(busy), 32'd1);
        check("beq_rv0", 32'(rif.redirect_valid), 32'd0);
        check("beq_lv", 32'(link_valid), 32'd0);
        step();
        check("beq_rv_noslot", 32'(rif.redirect_valid), 32'd0);
        slot_fetched = 1'b1;
        step();
        slot_fetched = 1'b0;
        check("beq_rv1", 32'(rif.redirect_valid), 32'd1);
        check("beq_addr", rif.redirect_addr, 32'h0000_00FC);
        step();
        check("beq_hold1", 32'(rif.redirect_valid), 32'd1);
        step();
        check("beq_hold2", 32'(rif.redirect_valid), 32'd1);
        check("beq_hold_addr", rif.redirect_addr, 32'h0000_00FC);
        rif.redirect_ready = 1'b1;
        step();
        rif.redirect_ready = 1'b0;
        check("beq_rv_clr", 32'(rif.redirect_valid), 32'd0);
        check("beq_busy_clr", 32'(busy), 32'd0);

        // BGEZAL not taken (rs negative), link still written
        instr(6'h01, 6'h0, 5'h11, 5'h0, 16'h0010, 26'h0,
              32'hFFFF_FFFF, 32'h0, 32'h400);
        step();
        instr_valid = 1'b0;
        check("bgezal_lv", 32'(link_valid), 32'd1);
        check("bgezal_lreg", 32'(link_reg), 32'd31);
        check("bgezal_laddr", link_addr, 32'h404);
        check("bgezal_busy", 32'(busy), 32'd0);
        step();
        check("bgezal_lv_pulse", 32'(link_valid), 32'd0);
        check("bgezal_rv", 32'(rif.redirect_valid), 32'd0);

        // JALR misaligned target: fault + link to rd, no redirect
        instr(6'h00, 6'h09, 5'h0, 5'd9, 16'h0, 26'h0,
              32'h0000_1002, 32'h0, 32'h200);
        step();
        instr_valid = 1'b0;
        check("jalr_fault", 32'(addr_fault), 32'd1);
        check("jalr_lv", 32'(link_valid), 32'd1);
        check("jalr_lreg", 32'(link_reg), 32'd9);
        check("jalr_laddr", link_addr, 32'h204);
        check("jalr_busy", 32'(busy), 32'd0);
        step();
        check("jalr_fault_pulse", 32'(addr_fault), 32'd0);
        check("jalr_rv", 32'(rif.redirect_valid), 32'd0);

        // slot_fetched while IDLE is ignored
        slot_fetched = 1'b1;
        step();
        slot_fetched = 1'b0;
        check("idle_slot_busy", 32'(busy), 32'd0);

        // J into upper region; BNE in SLOT must be ignored
        instr(6'h02, 6'h0, 5'h0, 5'h0, 16'h0, 26'h000_0040,
              32'h0, 32'h0, 32'hB000_0010);
        step();
        check("j_busy", 32'(busy), 32'd1);
        check("j_rv0", 32'(rif.redirect_valid), 32'd0);
        instr(6'h05, 6'h0, 5'h0, 5'h0, 16'h0100, 26'h0,
              32'd1, 32'd2, 32'h300);
        step();
        instr_valid = 1'b0;
        check("j_bne_ign_rv", 32'(rif.redirect_valid), 32'd0);
        check("j_bne_ign_lv", 32'(link_valid), 32'd0);
        slot_fetched = 1'b1;
        step();
        slot_fetched = 1'b0;
        check("j_rv1", 32'(rif.redirect_valid), 32'd1);
        check("j_addr", rif.redirect_addr, 32'hB000_0100);
        rif.redirect_ready = 1'b1;
        step();
        rif.redirect_ready = 1'b0;
        check("j_rv_clr", 32'(rif.redirect_valid), 32'd0);

        // Reset while in REDIRECT with ready low
        instr(6'h04, 6'h0, 5'h0, 5'h0, 16'h0001, 26'h0, 32'd7, 32'd7, 32'h100);
        step();
        instr_valid  = 1'b0;
        slot_fetched = 1'b1;
        step();
        slot_fetched = 1'b0;
        check("pre_rst_rv", 32'(rif.redirect_valid), 32'd1);
        check("pre_rst_addr", rif.redirect_addr, 32'h104);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_rv", 32'(rif.redirect_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);

        // BEQ after reset handled normally: 0x200 + 0x40 = 0x240
        instr(6'h04, 6'h0, 5'h0, 5'h0, 16'h0010, 26'h0, 32'd3, 32'd3, 32'h200);
        step();
        instr_valid = 1'b0;
        check("post_busy", 32'(busy), 32'd1);
        slot_fetched = 1'b1;
        step();
        slot_fetched = 1'b0;
        check("post_rv", 32'(rif.redirect_valid), 32'd1);
        check("post_addr", rif.redirect_addr, 32'h240);
        rif.redirect_ready = 1'b1;
        step();
        rif.redirect_ready = 1'b0;
        check("post_rv_clr", 32'(rif.redirect_valid), 32'd0);

`ifdef BRANCH_STATS_EN
        // Counters restart from the mid-op reset; one taken BEQ since
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            instr(6'h05, 6'h0, 5'h0, 5'h0, 16'h0004, 26'h0,
                  32'd1, 32'd2, 32'h500);
            step();
            instr_valid  = 1'b0;
            slot_fetched = 1'b1;
            step();
            slot_fetched       = 1'b0;
            rif.redirect_ready = 1'b1;
            step();
            rif.redirect_ready = 1'b0;
        end
        check("stat_taken_sat", 32'(taken_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            instr(6'h06, 6'h0, 5'h0, 5'h0, 16'h0004, 26'h0,
                  32'd1, 32'd0, 32'h600);
            step();
            instr_valid = 1'b0;
        end
        check("stat_not_taken", 32'(not_taken_count), 32'd3);
        check("stat_busy", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
